snitch_link_arbiter: RTL and testbench
======================================

SNITCH_LINK_ARBITER -- requirements
Module: snitch_link_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, request address width of the narrow chip link.
REQ-002 SHALL have parameter DW, default 4, data nibble width of the link.
REQ-003 SHALL have parameter TimeoutCycles, default 1024, idle-cycle limit per locked transaction; 0 disables the timeout.
REQ-004 SHALL have port clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports pN_req_addr_i in AW, pN_req_data_i in DW, pN_req_write_i in 1, pN_req_wstrb_i in 1, pN_req_valid_i in 1, pN_req_ready_o out 1; N in {0,1}; requester N request beat channel.
REQ-007 SHALL have ports pN_rsp_data_o out DW, pN_rsp_last_o out 1, pN_rsp_valid_o out 1, pN_rsp_ready_i in 1; N in {0,1}; requester N response channel.
REQ-008 SHALL have ports link_req_addr_o out AW, link_req_data_o out DW, link_req_write_o out 1, link_req_wstrb_o out 1, link_req_valid_o out 1, link_req_ready_i in 1; shared link request side.
REQ-009 SHALL have ports link_rsp_data_i in DW, link_rsp_last_i in 1, link_rsp_valid_i in 1, link_rsp_ready_o out 1; shared link response side.
REQ-010 SHALL have ports gnt_o out 2 (one-hot or zero, current owner), busy_o out 1 (state LOCKED), err_o out 1 (timeout pulse).

Function
REQ-011 SHALL implement FSM states IDLE and LOCKED, plus registered owner index g and priority pointer prio.
REQ-012 In IDLE: all pN_req_ready_o=0, pN_rsp_valid_o=0, link_req_valid_o=0, link_rsp_ready_o=0, gnt_o=2'b00.
REQ-013 In IDLE with exactly one pN_req_valid_i=1: next cycle LOCKED, g=N (one-cycle grant latency).
REQ-014 In IDLE with both valid: g=prio, next cycle LOCKED.
REQ-015 In LOCKED: link_req_* = pg_req_* (combinational mux), pg_req_ready_o = link_req_ready_i; non-owner req_ready_o=0.
REQ-016 In LOCKED: pg_rsp_data_o/last_o/valid_o = link_rsp_*, link_rsp_ready_o = pg_rsp_ready_i; non-owner rsp_valid_o=0, rsp_data_o=0, rsp_last_o=0.
REQ-017 Owner request beats SHALL pass unrestricted during LOCKED, including after the first response beat.
REQ-018 Transaction end: response handshake (link_rsp_valid_i & link_rsp_ready_o & link_rsp_last_i) -> next cycle IDLE, prio = ~g.
REQ-019 Response beats with last=0 SHALL NOT release the lock.
REQ-020 Timeout counter SHALL clear on entry to LOCKED and on any link request or response handshake; otherwise increment by 1 per LOCKED cycle, saturating.
REQ-021 If TimeoutCycles>0 and counter reaches TimeoutCycles-1 with no handshake this cycle: err_o=1 for exactly one cycle, next cycle IDLE, prio = ~g.
REQ-022 Counter width SHALL be $clog2(TimeoutCycles+1), minimum 1 bit.
REQ-023 End-of-transaction handshake and timeout in the same cycle: handshake wins, err_o stays 0.
REQ-024 IDLE-to-LOCKED decision SHALL depend only on valids sampled in IDLE; requester dropping valid after grant SHALL NOT release lock.
REQ-025 Back-to-back: after release, IDLE lasts at least one cycle before next grant.

Reset
REQ-026 rst_i=1 SHALL immediately force IDLE, g=0, prio=0, counter=0, err_o=0, all outputs per REQ-012.
REQ-027 Reset mid-transaction SHALL abandon the transaction with no err_o pulse; no beat forwarded while rst_i=1.

Verification
REQ-028 Single requester: p0 valid, addr 8'hA5, data 4'h3, ready=1 -> gnt_o=01 one cycle later, link_req_addr_o=8'hA5, p0_req_ready_o=1; rsp beats 4'h1,4'h2(last) reach p0 only; busy_o=0 cycle after last.
REQ-029 Contention after reset: p0,p1 valid same cycle -> p0 granted first; after its last rsp, p1 granted (gnt_o=10) after one IDLE cycle.
REQ-030 Round-robin: p1 transaction completes, then both valid -> p0 granted; p1 req_ready_o and rsp_valid_o stay 0 throughout.
REQ-031 Timeout: TimeoutCycles=8, p0 granted, link never ready/valid -> err_o=1 exactly 8 LOCKED cycles after grant, then IDLE, prio=1.
REQ-032 Last response coincides with timeout cycle -> normal release, err_o=0.
REQ-033 rst_i asserted while LOCKED mid-response -> outputs zero same cycle, gnt_o=00, err_o=0; after release p1-only request granted normally.

Source files
------------

// File: rtl/snitch_link_arbiter.sv
// Two-requester lock arbiter for the narrow chip link: one owner holds the link
// from grant until its last response beat (or a timeout), then priority flips.
module snitch_link_arbiter #(
  parameter int unsigned AW            = 8,
  parameter int unsigned DW            = 4,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] p0_req_addr_i,
  input  logic [DW-1:0] p0_req_data_i,
  input  logic          p0_req_write_i,
  input  logic          p0_req_wstrb_i,
  input  logic          p0_req_valid_i,
  output logic          p0_req_ready_o,
  output logic [DW-1:0] p0_rsp_data_o,
  output logic          p0_rsp_last_o,
  output logic          p0_rsp_valid_o,
  input  logic          p0_rsp_ready_i,
  input  logic [AW-1:0] p1_req_addr_i,
  input  logic [DW-1:0] p1_req_data_i,
  input  logic          p1_req_write_i,
  input  logic          p1_req_wstrb_i,
  input  logic          p1_req_valid_i,
  output logic          p1_req_ready_o,
  output logic [DW-1:0] p1_rsp_data_o,
  output logic          p1_rsp_last_o,
  output logic          p1_rsp_valid_o,
  input  logic          p1_rsp_ready_i,
  output logic [AW-1:0] link_req_addr_o,
  output logic [DW-1:0] link_req_data_o,
  output logic          link_req_write_o,
  output logic          link_req_wstrb_o,
  output logic          link_req_valid_o,
  input  logic          link_req_ready_i,
  input  logic [DW-1:0] link_rsp_data_i,
  input  logic          link_rsp_last_i,
  input  logic          link_rsp_valid_i,
  output logic          link_rsp_ready_o,
  output logic [1:0]    gnt_o,
  output logic          busy_o,
  output logic          err_o
);

  localparam int unsigned CW = (TimeoutCycles != 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CW-1:0] CNT_LIM = CW'((TimeoutCycles != 0) ? TimeoutCycles - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, LOCKED} state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          write;
    logic          wstrb;
    logic          valid;
  } req_t;

  state_e        state_q, state_d;
  logic          g_q, g_d, prio_q, prio_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_t          req0, req1, req_own;
  logic          rsp_ready_own, req_hs, rsp_hs;

  assign req0 = '{addr: p0_req_addr_i, data: p0_req_data_i, write: p0_req_write_i,
                  wstrb: p0_req_wstrb_i, valid: p0_req_valid_i};
  assign req1 = '{addr: p1_req_addr_i, data: p1_req_data_i, write: p1_req_write_i,
                  wstrb: p1_req_wstrb_i, valid: p1_req_valid_i};
  assign req_own       = g_q ? req1 : req0;
  assign rsp_ready_own = g_q ? p1_rsp_ready_i : p0_rsp_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      g_q     <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    g_d              = g_q;
    prio_d           = prio_q;
    cnt_d            = cnt_q;
    p0_req_ready_o   = 1'b0;
    p1_req_ready_o   = 1'b0;
    p0_rsp_data_o    = '0;
    p0_rsp_last_o    = 1'b0;
    p0_rsp_valid_o   = 1'b0;
    p1_rsp_data_o    = '0;
    p1_rsp_last_o    = 1'b0;
    p1_rsp_valid_o   = 1'b0;
    link_req_addr_o  = '0;
    link_req_data_o  = '0;
    link_req_write_o = 1'b0;
    link_req_wstrb_o = 1'b0;
    link_req_valid_o = 1'b0;
    link_rsp_ready_o = 1'b0;
    gnt_o            = 2'b00;
    busy_o           = 1'b0;
    err_o            = 1'b0;
    req_hs           = 1'b0;
    rsp_hs           = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Counter restarts for whichever transaction gets granted next.
        cnt_d = '0;
        if (p0_req_valid_i && p1_req_valid_i) begin
          g_d     = prio_q;
          state_d = LOCKED;
        end else if (p0_req_valid_i || p1_req_valid_i) begin
          g_d     = p1_req_valid_i;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        busy_o           = 1'b1;
        gnt_o            = g_q ? 2'b10 : 2'b01;
        link_req_addr_o  = req_own.addr;
        link_req_data_o  = req_own.data;
        link_req_write_o = req_own.write;
        link_req_wstrb_o = req_own.wstrb;
        link_req_valid_o = req_own.valid;
        link_rsp_ready_o = rsp_ready_own;
        if (g_q) begin
          p1_req_ready_o = link_req_ready_i;
          p1_rsp_data_o  = link_rsp_data_i;
          p1_rsp_last_o  = link_rsp_last_i;
          p1_rsp_valid_o = link_rsp_valid_i;
        end else begin
          p0_req_ready_o = link_req_ready_i;
          p0_rsp_data_o  = link_rsp_data_i;
          p0_rsp_last_o  = link_rsp_last_i;
          p0_rsp_valid_o = link_rsp_valid_i;
        end
        req_hs = req_own.valid && link_req_ready_i;
        rsp_hs = link_rsp_valid_i && rsp_ready_own;

        if (req_hs || rsp_hs)    cnt_d = '0;
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;

        // A completing handshake takes precedence over a coincident timeout.
        if (rsp_hs && link_rsp_last_i) begin
          state_d = IDLE;
          prio_d  = ~g_q;
        end else if ((TimeoutCycles != 0) && (cnt_q == CNT_LIM) && !req_hs && !rsp_hs) begin
          err_o   = 1'b1;
          state_d = IDLE;
          prio_d  = ~g_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_snitch_link_arbiter.sv
// Randomized and directed bench for snitch_link_arbiter against a cycle-level
// ownership model (owner / priority / quiet-cycle count).
module tb_snitch_link_arbiter;
  localparam int AW = 8;
  localparam int DW = 4;
  localparam int TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [AW-1:0] p0_req_addr_i, p1_req_addr_i, link_req_addr_o;
  logic [DW-1:0] p0_req_data_i, p1_req_data_i, link_req_data_o;
  logic          p0_req_write_i, p0_req_wstrb_i, p0_req_valid_i, p0_req_ready_o;
  logic          p1_req_write_i, p1_req_wstrb_i, p1_req_valid_i, p1_req_ready_o;
  logic [DW-1:0] p0_rsp_data_o, p1_rsp_data_o, link_rsp_data_i;
  logic          p0_rsp_last_o, p0_rsp_valid_o, p0_rsp_ready_i;
  logic          p1_rsp_last_o, p1_rsp_valid_o, p1_rsp_ready_i;
  logic          link_req_write_o, link_req_wstrb_o, link_req_valid_o, link_req_ready_i;
  logic          link_rsp_last_i, link_rsp_valid_i, link_rsp_ready_o;
  logic [1:0]    gnt_o;
  logic          busy_o, err_o;

  snitch_link_arbiter #(.AW(AW), .DW(DW), .TimeoutCycles(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p0_req_addr_i(p0_req_addr_i), .p0_req_data_i(p0_req_data_i), .p0_req_write_i(p0_req_write_i),
    .p0_req_wstrb_i(p0_req_wstrb_i), .p0_req_valid_i(p0_req_valid_i), .p0_req_ready_o(p0_req_ready_o),
    .p0_rsp_data_o(p0_rsp_data_o), .p0_rsp_last_o(p0_rsp_last_o), .p0_rsp_valid_o(p0_rsp_valid_o),
    .p0_rsp_ready_i(p0_rsp_ready_i),
    .p1_req_addr_i(p1_req_addr_i), .p1_req_data_i(p1_req_data_i), .p1_req_write_i(p1_req_write_i),
    .p1_req_wstrb_i(p1_req_wstrb_i), .p1_req_valid_i(p1_req_valid_i), .p1_req_ready_o(p1_req_ready_o),
    .p1_rsp_data_o(p1_rsp_data_o), .p1_rsp_last_o(p1_rsp_last_o), .p1_rsp_valid_o(p1_rsp_valid_o),
    .p1_rsp_ready_i(p1_rsp_ready_i),
    .link_req_addr_o(link_req_addr_o), .link_req_data_o(link_req_data_o),
    .link_req_write_o(link_req_write_o), .link_req_wstrb_o(link_req_wstrb_o),
    .link_req_valid_o(link_req_valid_o), .link_req_ready_i(link_req_ready_i),
    .link_rsp_data_i(link_rsp_data_i), .link_rsp_last_i(link_rsp_last_i),
    .link_rsp_valid_i(link_rsp_valid_i), .link_rsp_ready_o(link_rsp_ready_o),
    .gnt_o(gnt_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  // Model: own = -1 when idle, cnt = LOCKED cycles since entry/last handshake.
  int own, prio, cnt;
  logic hs_req_m, hs_rsp_m, done_m, to_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [AW+DW+2:0] lreq_e;
    logic [DW+1:0]    rsp_e;
    logic             rrdy_own;
    lreq_e   = '0;
    rrdy_own = 1'b0;
    rsp_e    = {link_rsp_data_i, link_rsp_last_i, link_rsp_valid_i};
    if (own == 0) begin
      lreq_e   = {p0_req_addr_i, p0_req_data_i, p0_req_write_i, p0_req_wstrb_i, p0_req_valid_i};
      rrdy_own = p0_rsp_ready_i;
    end else if (own == 1) begin
      lreq_e   = {p1_req_addr_i, p1_req_data_i, p1_req_write_i, p1_req_wstrb_i, p1_req_valid_i};
      rrdy_own = p1_rsp_ready_i;
    end
    hs_req_m = (own >= 0) && lreq_e[0] && link_req_ready_i;
    hs_rsp_m = (own >= 0) && link_rsp_valid_i && rrdy_own;
    done_m   = hs_rsp_m && link_rsp_last_i;
    to_m     = (own >= 0) && !hs_req_m && !hs_rsp_m && (cnt + 1 == TO);
    chk("gnt", gnt_o, (own < 0) ? 0 : (1 << own));
    chk("busy", busy_o, own >= 0);
    chk("err", err_o, to_m);
    chk("link_req", {link_req_addr_o, link_req_data_o, link_req_write_o, link_req_wstrb_o,
                     link_req_valid_o}, lreq_e);
    chk("link_rsp_ready", link_rsp_ready_o, rrdy_own);
    chk("p0_req_ready", p0_req_ready_o, (own == 0) && link_req_ready_i);
    chk("p1_req_ready", p1_req_ready_o, (own == 1) && link_req_ready_i);
    chk("p0_rsp", {p0_rsp_data_o, p0_rsp_last_o, p0_rsp_valid_o}, (own == 0) ? rsp_e : '0);
    chk("p1_rsp", {p1_rsp_data_o, p1_rsp_last_o, p1_rsp_valid_o}, (own == 1) ? rsp_e : '0);
  endtask

  task automatic model_step();
    if (own < 0) begin
      if (p0_req_valid_i && p1_req_valid_i) own = prio;
      else if (p0_req_valid_i)              own = 0;
      else if (p1_req_valid_i)              own = 1;
      cnt = 0;
    end else if (done_m || to_m) begin
      prio = 1 - own;
      own  = -1;
      cnt  = 0;
    end else begin
      cnt = (hs_req_m || hs_rsp_m) ? 0 : cnt + 1;
    end
  endtask

  // Inputs are set at the falling edge by the caller; check, advance, return at next falling edge.
  task automatic cycle();
    #1;
    check_outputs();
    model_step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    {p0_req_addr_i, p0_req_data_i, p0_req_write_i, p0_req_wstrb_i, p0_req_valid_i} = '0;
    {p1_req_addr_i, p1_req_data_i, p1_req_write_i, p1_req_wstrb_i, p1_req_valid_i} = '0;
    p0_rsp_ready_i = 1'b0; p1_rsp_ready_i = 1'b0; link_req_ready_i = 1'b0;
    link_rsp_data_i = '0; link_rsp_last_i = 1'b0; link_rsp_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    own = -1; prio = 0; cnt = 0;
    check_outputs();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic rand_inputs(input int quiet);
    p0_req_addr_i = 8'($urandom); p0_req_data_i = 4'($urandom);
    p1_req_addr_i = 8'($urandom); p1_req_data_i = 4'($urandom);
    p0_req_write_i = 1'($urandom); p0_req_wstrb_i = 1'($urandom);
    p1_req_write_i = 1'($urandom); p1_req_wstrb_i = 1'($urandom);
    p0_req_valid_i = ($urandom_range(0, 99) < 40);
    p1_req_valid_i = ($urandom_range(0, 99) < 40);
    p0_rsp_ready_i = ($urandom_range(0, 99) < 70);
    p1_rsp_ready_i = ($urandom_range(0, 99) < 70);
    link_req_ready_i = ($urandom_range(0, 99) < (quiet ? 4 : 50));
    link_rsp_valid_i = ($urandom_range(0, 99) < (quiet ? 4 : 40));
    link_rsp_last_i  = ($urandom_range(0, 2) == 0);
    link_rsp_data_i  = 4'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int seen;
    idle_inputs();
    rst_i = 1'b1;
    own = -1; prio = 0; cnt = 0;
    @(negedge clk_i);
    do_reset();

    // Single requester transaction with two response beats.
    p0_req_valid_i = 1'b1; p0_req_addr_i = 8'hA5; p0_req_data_i = 4'h3; link_req_ready_i = 1'b1;
    cycle();
    chk("single_gnt", gnt_o, 2'b01);
    chk("single_addr", link_req_addr_o, 8'hA5);
    chk("single_p0_ready", p0_req_ready_o, 1'b1);
    cycle();
    idle_inputs();
    p0_rsp_ready_i = 1'b1; link_rsp_valid_i = 1'b1; link_rsp_data_i = 4'h1;
    cycle();
    chk("single_busy_mid", busy_o, 1'b1);
    link_rsp_data_i = 4'h2; link_rsp_last_i = 1'b1;
    cycle();
    idle_inputs();
    chk("single_busy_after", busy_o, 1'b0);

    // Contention after reset, then round-robin back to p0.
    do_reset();
    p0_req_valid_i = 1'b1; p1_req_valid_i = 1'b1;
    cycle();
    chk("cont_gnt_p0", gnt_o, 2'b01);
    p0_req_valid_i = 1'b0;
    p0_rsp_ready_i = 1'b1; link_rsp_valid_i = 1'b1; link_rsp_last_i = 1'b1;
    cycle();
    chk("cont_idle_gap", gnt_o, 2'b00);
    link_rsp_valid_i = 1'b0;
    cycle();
    chk("cont_gnt_p1", gnt_o, 2'b10);
    p1_req_valid_i = 1'b0; p1_rsp_ready_i = 1'b1; link_rsp_valid_i = 1'b1;
    cycle();
    idle_inputs();
    p0_req_valid_i = 1'b1; p1_req_valid_i = 1'b1;
    cycle();
    chk("rr_gnt_p0", gnt_o, 2'b01);
    p1_req_valid_i = 1'b0; p0_req_valid_i = 1'b0;
    p0_rsp_ready_i = 1'b1; link_rsp_valid_i = 1'b1; link_rsp_last_i = 1'b1;
    cycle();
    idle_inputs();

    // Timeout: link silent after grant.
    p0_req_valid_i = 1'b1;
    cycle();
    p0_req_valid_i = 1'b0;
    seen = 0;
    for (int n = 1; n <= 20 && seen == 0; n++) begin
      #1;
      if (err_o) seen = n;
      cycle();
    end
    chk("timeout_cycles", seen, TO);
    chk("timeout_released", gnt_o, 2'b00);
    p0_req_valid_i = 1'b1; p1_req_valid_i = 1'b1;
    cycle();
    chk("timeout_prio_p1", gnt_o, 2'b10);
    idle_inputs();
    p1_rsp_ready_i = 1'b1; link_rsp_valid_i = 1'b1; link_rsp_last_i = 1'b1;
    cycle();
    idle_inputs();

    // Last response lands in the would-be timeout cycle.
    p0_req_valid_i = 1'b1;
    cycle();
    p0_req_valid_i = 1'b0;
    for (int n = 1; n < TO; n++) cycle();
    p0_rsp_ready_i = 1'b1; link_rsp_valid_i = 1'b1; link_rsp_last_i = 1'b1;
    #1;
    chk("coincide_err", err_o, 1'b0);
    cycle();
    idle_inputs();
    chk("coincide_released", busy_o, 1'b0);

    // Reset while mid-response, then a fresh p1 request.
    p0_req_valid_i = 1'b1;
    cycle();
    p0_req_valid_i = 1'b0; p0_rsp_ready_i = 1'b1; link_rsp_valid_i = 1'b1;
    cycle();
    do_reset();
    idle_inputs();
    p1_req_valid_i = 1'b1;
    cycle();
    chk("post_reset_gnt_p1", gnt_o, 2'b10);
    idle_inputs();

    // Randomized traffic with alternating busy and quiet link phases.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        rand_inputs(0);
        do_reset();
      end else begin
        rand_inputs((k / 150) % 2);
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
